// File: rtl/mont_decode_pkg.sv
// Field constants and types shared by the Montgomery exit converter and its QPMM core.
// Modulus 239, Montgomery radix R = 2^10; MOD_X2/MOD_X4 are the pre-shifted moduli used by reduction.
package mont_decode_pkg;

    localparam int unsigned bit_width       = 8;
    localparam int unsigned Mod             = 239;
    localparam int unsigned M_TILDE         = Mod;
    localparam int unsigned R_BITS          = 10;
    localparam int unsigned RED_STAGES_DEF  = 2;
    localparam int unsigned LAT_QPMM        = 2;
    localparam int unsigned LAT_MONT_DECODE = LAT_QPMM + RED_STAGES_DEF;
    localparam int unsigned MOD_X2          = Mod << 1;
    localparam int unsigned MOD_X4          = Mod << 2;

    // qpmm_fp_t holds any operand < 1024*M_tilde; uint_Mtilde2_t holds QPMM results < 4*Mod
    localparam int unsigned QPMM_FP_W = bit_width + R_BITS;
    localparam int unsigned MTILDE2_W = bit_width + RED_STAGES_DEF;

    typedef logic [QPMM_FP_W-1:0] qpmm_fp_t;
    typedef logic [MTILDE2_W-1:0] uint_Mtilde2_t;

    function automatic int unsigned mod_shifted(input int unsigned k);
        case (k)
            0:       return Mod;
            1:       return MOD_X2;
            2:       return MOD_X4;
            default: return Mod << k;
        endcase
    endfunction

endpackage

// File: rtl/QPMM_d0.sv
// Pipelined Montgomery multiplier: z = a*b*2^-R_BITS (mod Mod), redundant result.
// Bit-serial REDC split evenly over LAT_QPMM register stages.
module QPMM_d0
    import mont_decode_pkg::*;
(
    input  logic                 clk,
    input  qpmm_fp_t             a,
    input  logic [bit_width-1:0] b,
    output uint_Mtilde2_t        z
);

    localparam int unsigned PW   = QPMM_FP_W + bit_width;
    localparam int unsigned ITER = R_BITS / LAT_QPMM;

    logic [PW-1:0] s1;

    // Each step adds Mod when odd and halves; the sum never exceeds PW+1 bits.
    function automatic logic [PW-1:0] redc_steps(input logic [PW-1:0] v);
        logic [PW:0] t;
        t = {1'b0, v};
        for (int unsigned i = 0; i < ITER; i++) begin
            if (t[0]) t = t + (PW+1)'(Mod);
            t = t >> 1;
        end
        return t[PW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        s1 <= redc_steps(PW'(a) * PW'(b));
        z  <= uint_Mtilde2_t'(redc_steps(s1));
    end

endmodule

// File: rtl/mont_cond_sub.sv
// One registered conditional-subtract stage: y = (x >= Mod<<SHIFT) ? x - (Mod<<SHIFT) : x.
module mont_cond_sub
    import mont_decode_pkg::*;
#(
    parameter int unsigned SHIFT = 0,
    parameter int unsigned XW    = MTILDE2_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [XW-1:0] x,
    output logic [XW-1:0] y
);

    localparam logic [XW:0] SUB = (XW+1)'(mod_shifted(SHIFT));

    logic [XW:0] diff;

    // Top bit of the widened difference is the borrow: set means x < SUB, keep x.
    always_comb diff = {1'b0, x} - SUB;

    always_ff @(posedge clk) begin
        if (!rstn) y <= '0;
        else       y <= diff[XW] ? x : diff[XW-1:0];
    end

endmodule

// File: rtl/mont_decode.sv
// Montgomery-domain exit converter: out_data = in_data * R^-1 mod Mod, fixed latency, tag passthrough.
// Optional sticky range flag under `MONT_DECODE_RANGE_CHECK_EN.
module mont_decode
    import mont_decode_pkg::*;
#(
    parameter int unsigned RED_STAGES = RED_STAGES_DEF,
    parameter int unsigned TAG_W      = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  qpmm_fp_t             in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    output logic [bit_width-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 range_err
);

    localparam int unsigned XW  = bit_width + RED_STAGES;
    localparam int unsigned LAT = LAT_QPMM + RED_STAGES;

    uint_Mtilde2_t                  qpmm_z;
    logic [RED_STAGES:0][XW-1:0]    red_x;
    logic [LAT-1:0]                 vld_sr;
    logic [LAT-1:0][TAG_W-1:0]      tag_sr;

    QPMM_d0 u_qpmm (
        .clk (clk),
        .a   (in_data),
        .b   (bit_width'(1)),
        .z   (qpmm_z)
    );

    assign red_x[0] = XW'(qpmm_z);

    // Largest multiple first: stage g removes Mod << (RED_STAGES-1-g).
    for (genvar g = 0; g < RED_STAGES; g++) begin : g_red
        mont_cond_sub #(
            .SHIFT (RED_STAGES - 1 - g),
            .XW    (XW)
        ) u_sub (
            .clk  (clk),
            .rstn (rstn),
            .x    (red_x[g]),
            .y    (red_x[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_sr <= '0;
            tag_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LAT-2:0], in_valid};
            tag_sr <= {tag_sr[LAT-2:0], in_tag};
        end
    end

    assign out_valid = vld_sr[LAT-1];
    assign out_tag   = tag_sr[LAT-1];
    assign out_data  = red_x[RED_STAGES][bit_width-1:0];

`ifdef MONT_DECODE_RANGE_CHECK_EN
    logic err_q;

    always_comb range_err = err_q | (out_valid & (red_x[RED_STAGES] >= XW'(Mod)));

    always_ff @(posedge clk) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= range_err;
    end
`else
    logic [XW-bit_width-1:0] unused_hi;
    assign unused_hi = red_x[RED_STAGES][XW-1:bit_width];
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mont_decode.sv
// Directed-vector bench for mont_decode (Mod = 239, R = 1024, R^-1 mod Mod = 116).
module tb_mont_decode;
    import mont_decode_pkg::*;

    localparam int unsigned TAG_W = 8;
    localparam int unsigned R_INV = 116;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 in_valid = 1'b0;
    qpmm_fp_t             in_data = '0;
    logic [TAG_W-1:0]     in_tag = '0;
    logic                 out_valid;
    logic [bit_width-1:0] out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 range_err;

    always #5 clk = ~clk;

    mont_decode #(
        .RED_STAGES (RED_STAGES_DEF),
        .TAG_W      (TAG_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .range_err (range_err)
    );

    typedef struct {
        int unsigned data;
        int unsigned tag;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned model(input int unsigned a);
        return ((a % Mod) * R_INV) % Mod;
    endfunction

    // Latency is counted to the edge where a downstream register would capture the result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", out_data, e.data);
                    check("tag", out_tag, e.tag);
                    check("latency", cyc + 1 - e.cyc, LAT_MONT_DECODE);
                end
            end else if (sb.size() != 0 && (cyc + 1 - sb[0].cyc) >= LAT_MONT_DECODE) begin
                check("missing_valid", 0, 1);
            end
        end
    end

    task automatic send(input bit v, input int unsigned d, input int unsigned t, input int unsigned e);
        exp_t x;
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = qpmm_fp_t'(d);
        in_tag   = TAG_W'(t);
        if (v) begin
            x.data = e;
            x.tag  = t;
            x.cyc  = cyc + 1;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 0, 0);
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rstn     = 1'b0;
        mon_en   = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;
    endtask

    int unsigned vin [12] = '{68, 0, 239, 78, 1, 2, 3, 1024, 478, 956, 244735, 4660};
    int unsigned vexp[12] = '{ 1, 0,   0, 205, 116, 232, 109, 1, 0, 0, 123, 181};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_range_err", range_err, 0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) send(1'b1, vin[i], 8'hA0 + i, vexp[i]);
        drain();

        for (int i = 0; i < 16; i++) begin
            a = i * 15013 + 7;
            send(i % 2 == 0, a, i, model(a));
        end
        drain();

        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(1024 * Mod - 1, 0);
            send(1'b1, a, i, model(a));
        end
        drain();

        for (int i = 0; i < 5; i++) send(1'b1, 68, 8'h50 + i, 1);
        pulse_reset();
        idle(6);
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_queue", sb.size(), 0);
        send(1'b1, 78, 8'h77, 205);
        drain();

`ifdef MONT_DECODE_RANGE_CHECK_EN
        @(posedge clk);
        #1;
        force dut.qpmm_z = uint_Mtilde2_t'(4 * Mod + 3);
        send(1'b1, 5, 8'hEE, 4 * Mod + 3 - MOD_X2 - Mod);
        idle(3);
        release dut.qpmm_z;
        drain();
        check("range_err_set", range_err, 1);
        idle(4);
        @(negedge clk);
        check("range_err_held", range_err, 1);
        pulse_reset();
        @(negedge clk);
        check("range_err_clear", range_err, 0);
`else
        @(negedge clk);
        check("range_err_idle", range_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
